// File: rtl/frog_move_ctrl_pkg.sv
// Shared frogger definitions: controller state encoding, grid defaults and
// the switch bundle that is edge-detected by the controller.
package frog_move_ctrl_pkg;

    localparam int unsigned GRID_COLS_DEF = 20;
    localparam int unsigned GRID_ROWS_DEF = 15;
    localparam int unsigned COORD_W_DEF   = 6;
    localparam int unsigned LIVES_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } frog_state_e;

    // Inputs whose rising edges drive the controller; game_active is the MSB.
    typedef struct packed {
        logic game_active;
        logic up;
        logic down;
        logic left;
        logic right;
    } sw_vec_t;

    localparam int unsigned SW_N = $bits(sw_vec_t);

endpackage

// File: rtl/btn_edge_det.sv
// Parametrised N-bit rising-edge detector.
//  clk, rst_n : clock, async active-low reset
//  i_sig      : synchronous level inputs
//  o_edge_c   : combinational one-cycle pulse per bit on a 0->1 transition
module btn_edge_det #(
    parameter int unsigned N = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_sig,
    output logic [N-1:0] o_edge_c
);

    logic [N-1:0] prev_d;
    logic [N-1:0] prev_q;

    always_comb begin
        prev_d = i_sig;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign o_edge_c = i_sig & ~prev_q;

endmodule

// File: rtl/frog_move_ctrl.sv
// Frog controller: grid-bounded hops with cooldown, goal scoring, hazard
// death with blink-and-respawn, lives and game-over.
//  i_Clk, i_Rst_L           : pixel clock, async active-low reset
//  i_Game_Active            : level, rising edge starts a new game
//  i_Up/Down/Left/Right     : debounced switches, hop on rising edge
//  i_Hazard                 : frog tile overlaps a car / water this cycle
//  i_Col/Row_Count_Div      : current pixel position in tiles
//  o_Draw_Frog              : registered, frog occupies the current tile
//  o_Frog_X/Y, o_Score, o_Lives, o_Dying, o_Game_Over : game status
module frog_move_ctrl
    import frog_move_ctrl_pkg::*;
#(
    parameter int unsigned GRID_COLS    = GRID_COLS_DEF,
    parameter int unsigned GRID_ROWS    = GRID_ROWS_DEF,
    parameter int unsigned COORD_W      = COORD_W_DEF,
    parameter int unsigned START_X      = 10,
    parameter int unsigned START_Y      = 14,
    parameter int unsigned GOAL_ROW     = 0,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned SCORE_W      = 7,
    parameter int unsigned HOP_COOLDOWN = 2500000,
    parameter int unsigned DEATH_TICKS  = 25000000,
    parameter int unsigned BLINK_BIT    = 22
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_Game_Active,
    input  logic               i_Up,
    input  logic               i_Down,
    input  logic               i_Left,
    input  logic               i_Right,
    input  logic               i_Hazard,
    input  logic [COORD_W-1:0] i_Col_Count_Div,
    input  logic [COORD_W-1:0] i_Row_Count_Div,
    output logic               o_Draw_Frog,
    output logic [COORD_W-1:0] o_Frog_X,
    output logic [COORD_W-1:0] o_Frog_Y,
    output logic [SCORE_W-1:0] o_Score,
    output logic [LIVES_W-1:0] o_Lives,
    output logic               o_Dying,
    output logic               o_Game_Over
);

    localparam int unsigned CD_W = $clog2(HOP_COOLDOWN + 1);
    localparam int unsigned DT_W = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;

    localparam logic [COORD_W-1:0] X_START = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] Y_START = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] Y_GOAL  = COORD_W'(GOAL_ROW);
    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(GRID_COLS - 1);
    localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(GRID_ROWS - 1);
    localparam logic [CD_W-1:0]    CD_LOAD = CD_W'(HOP_COOLDOWN);
    localparam logic [DT_W-1:0]    DT_LAST = DT_W'(DEATH_TICKS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    frog_state_e        state_d, state_q;
    logic [COORD_W-1:0] x_d, x_q, y_d, y_q;
    logic [SCORE_W-1:0] score_d, score_q;
    logic [LIVES_W-1:0] lives_d, lives_q;
    logic [CD_W-1:0]    cool_d, cool_q;
    logic [DT_W-1:0]    death_d, death_q;
    logic               draw_d, draw_q;
    logic               tile_hit;
    logic               visible;

    sw_vec_t          sw_raw;
    sw_vec_t          sw_edge;
    logic [SW_N-1:0]  sw_edge_vec;

    assign sw_raw  = {i_Game_Active, i_Up, i_Down, i_Left, i_Right};
    assign sw_edge = sw_vec_t'(sw_edge_vec);

    btn_edge_det #(
        .N (SW_N)
    ) u_edge_det (
        .clk      (i_Clk),
        .rst_n    (i_Rst_L),
        .i_sig    (sw_raw),
        .o_edge_c (sw_edge_vec)
    );

    // Next-state, movement, scoring, lives and draw decision.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        score_d  = score_q;
        lives_d  = lives_q;
        cool_d   = cool_q;
        death_d  = death_q;
        tile_hit = (i_Col_Count_Div == x_q) && (i_Row_Count_Div == y_q);
        visible  = 1'b0;

        if (cool_q != '0) begin
            cool_d = cool_q - CD_W'(1);
        end

        if (!i_Game_Active) begin
            // Score and lives stay put so they can still be displayed.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (sw_edge.game_active) begin
                        state_d = ST_PLAY;
                        x_d     = X_START;
                        y_d     = Y_START;
                        score_d = '0;
                        lives_d = LIVES_W'(LIVES);
                        cool_d  = '0;
                    end
                end
                ST_PLAY: begin
                    if (i_Hazard) begin
                        state_d = ST_DYING;
                        death_d = '0;
                        if (lives_q != '0) begin
                            lives_d = lives_q - LIVES_W'(1);
                        end
                    end else if (y_q == Y_GOAL) begin
                        if (score_q != SCORE_MAX) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                        x_d    = X_START;
                        y_d    = Y_START;
                        cool_d = CD_LOAD;
                    end else if (cool_q == '0) begin
                        // Fixed priority; a blocked hop at the edge does not arm the cooldown.
                        if (sw_edge.up) begin
                            if (y_q != '0) begin
                                y_d    = y_q - COORD_W'(1);
                                cool_d = CD_LOAD;
                            end
                        end else if (sw_edge.down) begin
                            if (y_q != Y_LAST) begin
                                y_d    = y_q + COORD_W'(1);
                                cool_d = CD_LOAD;
                            end
                        end else if (sw_edge.left) begin
                            if (x_q != '0) begin
                                x_d    = x_q - COORD_W'(1);
                                cool_d = CD_LOAD;
                            end
                        end else if (sw_edge.right) begin
                            if (x_q != X_LAST) begin
                                x_d    = x_q + COORD_W'(1);
                                cool_d = CD_LOAD;
                            end
                        end
                    end
                end
                ST_DYING: begin
                    if (death_q == DT_LAST) begin
                        death_d = '0;
                        if (lives_q == '0) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d = ST_PLAY;
                            x_d     = X_START;
                            y_d     = Y_START;
                            cool_d  = '0;
                        end
                    end else begin
                        death_d = death_q + DT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        case (state_q)
            ST_PLAY, ST_OVER: visible = 1'b1;
            ST_DYING:         visible = ~death_q[BLINK_BIT];
            default:          visible = 1'b0;
        endcase
        draw_d = tile_hit & visible;
    end

    // State and datapath registers.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= ST_IDLE;
            x_q     <= X_START;
            y_q     <= Y_START;
            score_q <= '0;
            lives_q <= LIVES_W'(LIVES);
            cool_q  <= '0;
            death_q <= '0;
            draw_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            score_q <= score_d;
            lives_q <= lives_d;
            cool_q  <= cool_d;
            death_q <= death_d;
            draw_q  <= draw_d;
        end
    end

    assign o_Draw_Frog = draw_q;
    assign o_Frog_X    = x_q;
    assign o_Frog_Y    = y_q;
    assign o_Score     = score_q;
    assign o_Lives     = lives_q;
    assign o_Dying     = (state_q == ST_DYING);
    assign o_Game_Over = (state_q == ST_OVER);

endmodule
